// File: rtl/startup_pkg.sv
// Shared types for the startup sequencer: 2-bit state enum, its encodings,
// and a helper used to size the shared cycle counter.
package startup_pkg;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] ENC_WAIT_LOCK = 2'd0;
   localparam logic [STATE_W-1:0] ENC_ROC       = 2'd1;
   localparam logic [STATE_W-1:0] ENC_TOC       = 2'd2;
   localparam logic [STATE_W-1:0] ENC_DONE      = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      ST_WAIT_LOCK = ENC_WAIT_LOCK,
      ST_ROC       = ENC_ROC,
      ST_TOC       = ENC_TOC,
      ST_DONE      = ENC_DONE
   } state_e;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/startup_cnt.sv
// Clearable incrementing counter with a terminal-value compare; used both for
// the phase timer and for the lock-wait watchdog.
module startup_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] term_i,
   output logic         hit_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/startup_seq_ctrl.sv
// Power-up release sequencer: qualify lock, hold gsr/prld, then gts, then enable gwe.
// Optional lock-wait watchdog is built only when STARTUP_WDOG_EN is defined.
module startup_seq_ctrl
   import startup_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 16,
   parameter int unsigned ROC_CYCLES  = 64,
   parameter int unsigned TOC_CYCLES  = 4,
   parameter int unsigned WDOG_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pll_locked,
   input  logic               restart_req,
   output logic               gsr,
   output logic               prld,
   output logic               gts,
   output logic               gwe,
   output logic               startup_done,
   output logic [STATE_W-1:0] state_o,
   output logic               lock_timeout
);

   localparam int unsigned CNT_W = $clog2(max3(LOCK_CYCLES, ROC_CYCLES, TOC_CYCLES) + 1);

   localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ROC_TERM  = CNT_W'(ROC_CYCLES - 1);
   // TOC is never entered when TOC_CYCLES is zero, so its terminal is then irrelevant.
   localparam logic [CNT_W-1:0] TOC_TERM  = CNT_W'((TOC_CYCLES == 0) ? 0 : TOC_CYCLES - 1);

   state_e           state_q;
   state_e           state_d;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_hit;
   logic [CNT_W-1:0] cnt_term;

   logic gsr_q, gsr_d;
   logic gts_q, gts_d;
   logic gwe_q, gwe_d;

   always_comb begin
      cnt_term = LOCK_TERM;
      case (state_q)
         ST_ROC:  cnt_term = ROC_TERM;
         ST_TOC:  cnt_term = TOC_TERM;
         default: cnt_term = LOCK_TERM;
      endcase
   end

   startup_cnt #(.W(CNT_W)) u_phase_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .term_i (cnt_term),
      .hit_o  (cnt_hit)
   );

   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (!pll_locked) begin
               cnt_clr = 1'b1;
            end else if (cnt_hit) begin
               state_d = ST_ROC;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_ROC: begin
            if (!pll_locked) begin
               state_d = ST_WAIT_LOCK;
               cnt_clr = 1'b1;
            end else if (cnt_hit) begin
               state_d = (TOC_CYCLES == 0) ? ST_DONE : ST_TOC;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_TOC: begin
            if (!pll_locked) begin
               state_d = ST_WAIT_LOCK;
               cnt_clr = 1'b1;
            end else if (cnt_hit) begin
               state_d = ST_DONE;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            // Lock loss and restart together still give exactly one return to WAIT_LOCK.
            cnt_clr = 1'b1;
            if (!pll_locked || restart_req) begin
               state_d = ST_WAIT_LOCK;
            end
         end
      endcase
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_comb begin
      gsr_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_ROC);
      gts_d = (state_d != ST_DONE);
      gwe_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT_LOCK;
         gsr_q   <= 1'b1;
         gts_q   <= 1'b1;
         gwe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gsr_q   <= gsr_d;
         gts_q   <= gts_d;
         gwe_q   <= gwe_d;
      end
   end

   assign gsr          = gsr_q;
   assign prld         = gsr_q;
   assign gts          = gts_q;
   assign gwe          = gwe_q;
   assign startup_done = gwe_q;
   assign state_o      = state_q;

`ifdef STARTUP_WDOG_EN
   localparam int unsigned      WD_W    = $clog2(WDOG_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_TERM = WD_W'(WDOG_CYCLES - 1);

   logic in_wait;
   logic wd_hit;
   logic timeout_q;
   logic timeout_d;

   assign in_wait = (state_q == ST_WAIT_LOCK);

   // Saturates at the terminal so a long lock wait cannot wrap the counter.
   startup_cnt #(.W(WD_W)) u_wdog_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (!in_wait),
      .inc_i  (in_wait && !wd_hit),
      .term_i (WD_TERM),
      .hit_o  (wd_hit)
   );

   assign timeout_d = timeout_q || (in_wait && wd_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign lock_timeout = timeout_q;
`else
   assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_startup_seq_ctrl.sv
// Directed bench for startup_seq_ctrl: one instance with TOC=2 and one with TOC=0,
// driven from shared inputs; watchdog checks are compiled when STARTUP_WDOG_EN is set.
module tb_startup_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       restart_req;

   logic       gsr_a, prld_a, gts_a, gwe_a, done_a, lt_a;
   logic [1:0] state_a;
   logic       gsr_b, prld_b, gts_b, gwe_b, done_b, lt_b;
   logic [1:0] state_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   startup_seq_ctrl #(
      .LOCK_CYCLES(4), .ROC_CYCLES(8), .TOC_CYCLES(2), .WDOG_CYCLES(100)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .restart_req(restart_req),
      .gsr(gsr_a), .prld(prld_a), .gts(gts_a), .gwe(gwe_a),
      .startup_done(done_a), .state_o(state_a), .lock_timeout(lt_a)
   );

   startup_seq_ctrl #(
      .LOCK_CYCLES(4), .ROC_CYCLES(8), .TOC_CYCLES(0), .WDOG_CYCLES(100)
   ) u_dut_toc0 (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .restart_req(restart_req),
      .gsr(gsr_b), .prld(prld_b), .gts(gts_b), .gwe(gwe_b),
      .startup_done(done_b), .state_o(state_b), .lock_timeout(lt_b)
   );

   // Packed view: {lock_timeout, gsr, prld, gts, gwe, startup_done, state[1:0]}
   function automatic logic [7:0] obs_a();
      return {lt_a, gsr_a, prld_a, gts_a, gwe_a, done_a, state_a};
   endfunction

   function automatic logic [7:0] obs_b();
      return {lt_b, gsr_b, prld_b, gts_b, gwe_b, done_b, state_b};
   endfunction

   function automatic logic [7:0] pack_exp(input logic lt, input logic [1:0] st);
      logic g;
      g = (st == 2'd0) || (st == 2'd1);
      return {lt, g, g, (st != 2'd3), (st == 2'd3), (st == 2'd3), st};
   endfunction

   // Expected state after edge k of a clean run: LOCK=4 -> ROC after edge 3,
   // ROC=8 -> TOC after edge 11, TOC=2 -> DONE after edge 13.
   function automatic logic [1:0] st_a_at(input int k);
      if (k < 3)  return 2'd0;
      if (k < 11) return 2'd1;
      if (k < 13) return 2'd2;
      return 2'd3;
   endfunction

   function automatic logic [1:0] st_b_at(input int k);
      if (k < 3)  return 2'd0;
      if (k < 11) return 2'd1;
      return 2'd3;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset(input logic lock);
      @(negedge clk);
      rst_n       = 1'b0;
      restart_req = 1'b0;
      pll_locked  = lock;
      #1;
      check("reset_a", obs_a(), 8'h70);
      check("reset_b", obs_b(), 8'h70);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs edges 0..13 with lock held high; optional restart pulse at edge 6 (ROC).
   task automatic run_seq(input string tag, input logic lt, input bit restart_in_roc);
      for (int k = 0; k < 14; k++) begin
         restart_req = restart_in_roc && (k == 6);
         step();
         restart_req = 1'b0;
         check($sformatf("%s_a_e%0d", tag, k), obs_a(), pack_exp(lt, st_a_at(k)));
         check($sformatf("%s_b_e%0d", tag, k), obs_b(), pack_exp(lt, st_b_at(k)));
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      pll_locked  = 1'b1;
      restart_req = 1'b0;

      apply_reset(1'b1);
      run_seq("seq", 1'b0, 1'b0);

      // Restart from DONE, then identical rerun with an ignored restart in ROC.
      restart_req = 1'b1;
      step();
      restart_req = 1'b0;
      check("restart_a", obs_a(), 8'h70);
      check("restart_b", obs_b(), 8'h70);
      run_seq("rerun", 1'b0, 1'b1);

      // Lock loss together with restart in DONE: one return to WAIT_LOCK, count from zero.
      pll_locked  = 1'b0;
      restart_req = 1'b1;
      step();
      pll_locked  = 1'b1;
      restart_req = 1'b0;
      check("loss_restart_a", obs_a(), 8'h70);
      check("loss_restart_b", obs_b(), 8'h70);
      run_seq("after_loss", 1'b0, 1'b0);

      // Back to a fresh start, then drop lock at edge 12 while in TOC.
      apply_reset(1'b1);
      for (int k = 0; k < 12; k++) step();
      check("pre_drop_a", obs_a(), 8'h12);
      pll_locked = 1'b0;
      step();
      check("drop_toc_a", obs_a(), 8'h70);
      check("drop_done_b", obs_b(), 8'h70);

      // Lock pulse low at edge 2 restarts qualification; gsr falls after edge 14.
      for (int k = 0; k < 15; k++) begin
         pll_locked = (k != 2);
         step();
         if (k == 5)  check("pulse_e5_a", obs_a(), 8'h70);
         if (k == 6)  check("pulse_e6_a", obs_a(), 8'h71);
         if (k == 13) check("pulse_e13_a", obs_a(), 8'h71);
         if (k == 14) check("pulse_e14_a", obs_a(), 8'h12);
         if (k == 14) check("pulse_e14_b", obs_b(), 8'h0F);
      end
      pll_locked = 1'b1;

      // Asynchronous reset mid-sequence acts without waiting for a clock edge.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_a", obs_a(), 8'h70);
      check("async_rst_b", obs_b(), 8'h70);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef STARTUP_WDOG_EN
      apply_reset(1'b0);
      for (int k = 0; k < 100; k++) begin
         step();
         if (k == 98) check("wdog_e98", {7'd0, lt_a}, 8'd0);
         if (k == 99) check("wdog_e99", {7'd0, lt_a}, 8'd1);
      end
      pll_locked = 1'b1;
      run_seq("wdog_seq", 1'b1, 1'b0);
      restart_req = 1'b1;
      step();
      restart_req = 1'b0;
      check("wdog_restart", obs_a(), 8'hF0);
      apply_reset(1'b1);
      check("wdog_cleared", {7'd0, lt_a}, 8'd0);
`else
      pll_locked = 1'b0;
      for (int k = 0; k < 120; k++) step();
      check("no_wdog_a", obs_a(), 8'h70);
      check("no_wdog_b", obs_b(), 8'h70);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
